// File: rtl/prm_edge_mask_collector.sv
// -----------------------------------------------------------------------------
// prm_edge_mask_collector
//
// Purpose:
//   Sits behind the replicated obstacle checker bank. One obstacle code is
//   broadcast to every checker per cycle, and each checker returns one
//   edge_mask bit. This block ORs those edge_mask vectors into a sticky
//   blocked-edge bitmap over the whole obstacle list. When the list ends, it
//   drains the bitmap in OUT_W-bit words to the roadmap graph memory.
//
// Parameters:
//   NUM_EDGE  number of roadmap edges (one checker each). It must be an
//             integer multiple of OUT_W.
//   OUT_W     width of each drained bitmap word.
//   CNT_W     width of the saturating obstacle sample counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle pulse: clear accumulator, begin a new pass
//   in_valid    in_mask / in_last valid this cycle
//   in_ready    collector accepts in_mask this cycle (high only in ACCUM)
//   in_mask     edge_mask bits, bit e = edge e blocked
//   in_last     qualifies the final obstacle sample of the pass
//   out_valid   out_data holds a bitmap word (high only in DRAIN)
//   out_ready   consumer accepts the word
//   out_data    blocked bits for edges out_idx*OUT_W .. out_idx*OUT_W+OUT_W-1
//   out_idx     word index
//   out_last    high with the final word
//   busy        high whenever the FSM is not IDLE
//   obs_count   samples accepted in the current or last pass (saturating)
//   dbg_state   current FSM state encoding (0=IDLE, 1=ACCUM, 2=DRAIN)
//   blocked_cnt (only with PRM_EDGE_POPCNT_EN) number of blocked edges
//               drained in the current or last pass
//
// Optional feature macro: PRM_EDGE_POPCNT_EN
//   When this macro is defined, the blocked_cnt output and its popcount
//   accumulator are added. When it is undefined, both are absent.
//
// Handshake semantics (both interfaces):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer holds its data stable while valid is high and ready is
//   low. in_ready and out_valid are decoded combinationally from the state
//   register only. They never depend on in_valid or out_ready.
// -----------------------------------------------------------------------------
module prm_edge_mask_collector #(
    parameter  int NUM_EDGE  = 512,
    parameter  int OUT_W     = 32,
    parameter  int CNT_W     = 16,
    localparam int NUM_WORDS = NUM_EDGE / OUT_W,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BC_W      = $clog2(NUM_EDGE + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_EDGE-1:0] in_mask,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_last,
    output logic                busy,
    output logic [CNT_W-1:0]    obs_count,
`ifdef PRM_EDGE_POPCNT_EN
    output logic [BC_W-1:0]     blocked_cnt,
`endif
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [NUM_EDGE-1:0] accum_q, accum_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;

    // Both the drain word and the popcount read the registered accumulator.
    // This keeps out_data stable during a stall.
    logic [OUT_W-1:0]    word_sel;

    always_comb begin
        word_sel = accum_q[idx_q * OUT_W +: OUT_W];
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            accum_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            accum_q <= accum_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accum_d   = accum_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // in_valid is deliberately not looked at here.
                // The last pass's bitmap and count stay visible until start.
                if (start) begin
                    accum_d = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accum_d = accum_q | in_mask;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // The last sample is already merged above. The first word
                    // can therefore be presented on the very next cycle.
                    if (in_last) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data  = word_sel;
    assign out_idx   = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign obs_count = cnt_q;
    assign dbg_state = state_q;

`ifdef PRM_EDGE_POPCNT_EN
    // -------------------------------------------------------------------------
    // Blocked-edge popcount, summed over the words accepted by the consumer.
    // -------------------------------------------------------------------------
    function automatic logic [BC_W-1:0] popcount(input logic [OUT_W-1:0] w);
        logic [BC_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < OUT_W; i++) begin
            sum = sum + BC_W'(w[i]);
        end
        return sum;
    endfunction

    logic [BC_W-1:0] blocked_q, blocked_d;

    always_comb begin
        blocked_d = blocked_q;
        if ((state_q == S_IDLE) && start) begin
            blocked_d = '0;
        end else if ((state_q == S_DRAIN) && out_ready) begin
            blocked_d = blocked_q + popcount(word_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocked_q <= '0;
        end else begin
            blocked_q <= blocked_d;
        end
    end

    assign blocked_cnt = blocked_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_collector.sv
module tb_prm_edge_mask_collector;

  localparam int NUM_EDGE = 64;
  localparam int OUT_W    = 32;
  localparam int CNT_W    = 4;
  localparam int IDX_W    = 1;
  localparam int W        = OUT_W + IDX_W + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                start, in_valid, in_last, out_ready;
  logic [NUM_EDGE-1:0] in_mask;
  logic                in_ready, out_valid, out_last, busy;
  logic [OUT_W-1:0]    out_data;
  logic [IDX_W-1:0]    out_idx;
  logic [CNT_W-1:0]    obs_count;
  logic [1:0]          dbg_state;
`ifdef PRM_EDGE_POPCNT_EN
  logic [6:0]          blocked_cnt;
`endif

  prm_edge_mask_collector #(
    .NUM_EDGE (NUM_EDGE),
    .OUT_W    (OUT_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mask     (in_mask),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .obs_count   (obs_count),
`ifdef PRM_EDGE_POPCNT_EN
    .blocked_cnt (blocked_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [OUT_W-1:0] data, input int idx, input logic last);
    logic [IDX_W-1:0] i;
    i = IDX_W'(idx);
    exp_q.push_back({last, i, data});
  endtask

  // The monitor compares every presented word (stalled or not) with the head
  // of the queue. It pops the head only when the word is accepted.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=0x%0h expected=none", {out_last, out_idx, out_data});
      end else begin
        check("drain_word", 64'({out_last, out_idx, out_data}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [NUM_EDGE-1:0] mask, input logic last);
    check("in_ready_accum", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mask  = mask;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mask  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_blocked(input int exp);
`ifdef PRM_EDGE_POPCNT_EN
    check("blocked_cnt", 64'(blocked_cnt), 64'(exp));
`else
    if (exp < 0) $display("unused %0d", exp);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mask = '0; out_ready = 1'b1;
    #12;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_obs_count", 64'(obs_count), 64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    check_blocked(0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic pass: 0x1 | bit63 | 0x10
    do_start();
    check("start_state", 64'(dbg_state), 64'd1);
    check("start_obs",   64'(obs_count), 64'd0);
    push_word(32'h0000_0011, 0, 1'b0);
    push_word(32'h8000_0000, 1, 1'b1);
    send(64'h0000_0000_0000_0001, 1'b0);
    send(64'h8000_0000_0000_0000, 1'b0);
    send(64'h0000_0000_0000_0010, 1'b1);
    check("p1_first_valid", 64'(out_valid), 64'd1);
    check("p1_first_idx",   64'(out_idx),   64'd0);
    check("p1_first_last",  64'(out_last),  64'd0);
    check("p1_obs",         64'(obs_count), 64'd3);
    wait_idle();
    check_blocked(3);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_mask = '1; in_last = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; in_mask = '0; in_last = 1'b0;
    check("idle_obs",      64'(obs_count), 64'd3);
    check("idle_state",    64'(dbg_state), 64'd0);
    check("idle_in_ready", 64'(in_ready),  64'd0);

    // start ignored in ACCUM and DRAIN; 5-cycle stall in DRAIN
    do_start();
    send(64'h0000_0000_0000_0100, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accum_start_state", 64'(dbg_state), 64'd1);
    check("accum_start_obs",   64'(obs_count), 64'd1);
    out_ready = 1'b0;
    push_word(32'h0000_0100, 0, 1'b0);
    push_word(32'h0000_0001, 1, 1'b1);
    send(64'h0000_0001_0000_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_idx",   64'(out_idx),   64'd0);
      check("stall_state", 64'(dbg_state), 64'd2);
    end
    start = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("p2_obs", 64'(obs_count), 64'd2);
    check_blocked(2);

    // 20 all-ones samples: count saturates at 15
    do_start();
    push_word(32'hFFFF_FFFF, 0, 1'b0);
    push_word(32'hFFFF_FFFF, 1, 1'b1);
    for (int i = 0; i < 20; i++) send('1, (i == 19));
    check("sat_obs", 64'(obs_count), 64'd15);
    wait_idle();
    check_blocked(64);

    // Back-to-back pass: start on the cycle right after out_last was accepted
    do_start();
    check("b2b_state", 64'(dbg_state), 64'd1);
    check("b2b_obs",   64'(obs_count), 64'd0);
    push_word(32'h0000_0000, 0, 1'b0);
    push_word(32'h0000_0004, 1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b0);
    send(64'h0000_0004_0000_0000, 1'b1);
    check("b2b_obs_end", 64'(obs_count), 64'd2);
    wait_idle();
    check_blocked(1);

    // Reset mid-ACCUM: the pass is abandoned with no words
    do_start();
    send(64'h0000_0000_0000_00FF, 1'b0);
    send(64'h0000_0000_0000_FF00, 1'b0);
    check("pre_rst_obs", 64'(obs_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_obs",       64'(obs_count), 64'd0);
    check("mid_rst_state",     64'(dbg_state), 64'd0);
    check_blocked(0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_start();
    push_word(32'h0000_0002, 0, 1'b0);
    push_word(32'h0000_0000, 1, 1'b1);
    send(64'h0000_0000_0000_0002, 1'b1);
    check("post_rst_obs", 64'(obs_count), 64'd1);
    wait_idle();
    check_blocked(1);

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
